// File: rtl/zvc_line_serializer.sv
// Purpose : serializes one zero-value-compressed line into fixed-width beats,
//           sending only the beats that hold valid (non-zero) words.
// Latency : first beat one cycle after line accept; back-to-back lines with no bubble.
// Backpr. : out_* held stable while out_valid && !out_ready; in_ready only in IDLE
//           or on the handshake of the final beat of the current line.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            line handshake; lifm_comp, mt_comp, nnz carry the line
//   out_valid/out_ready          beat handshake
//   out_lifm, out_mt, out_mask   beat words, mapping entries, per-word valid bits
//   out_beat_idx, out_last       beat index within the line, final-beat flag
//   perf_lines/beats/stall       saturating counters, only with `define ZVC_SER_PERF_EN
module zvc_line_serializer #(
  parameter int WORD_WIDTH    = 8,
  parameter int LINE_SIZE     = 128,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 4,
  parameter int BEAT_WORDS    = 16,
  localparam int MTW    = DIST_WIDTH * MAX_LIFM_RSIZ,
  localparam int NBEATS = LINE_SIZE / BEAT_WORDS,
  localparam int NW     = $clog2(LINE_SIZE) + 1,
  localparam int BIW    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp,
  input  logic [LINE_SIZE*MTW-1:0]      mt_comp,
  input  logic [NW-1:0]                 nnz,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BEAT_WORDS*WORD_WIDTH-1:0] out_lifm,
  output logic [BEAT_WORDS*MTW-1:0]     out_mt,
  output logic [BEAT_WORDS-1:0]         out_mask,
  output logic [BIW-1:0]                out_beat_idx,
`ifdef ZVC_SER_PERF_EN
  output logic [31:0]                   perf_lines,
  output logic [31:0]                   perf_beats,
  output logic [31:0]                   perf_stall,
`endif
  output logic                          out_last
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]                          r_state;
  logic [LINE_SIZE*WORD_WIDTH-1:0]     r_lifm;
  logic [LINE_SIZE*MTW-1:0]            r_mt;
  logic [NW-1:0]                       r_nnz;
  logic [BIW-1:0]                      r_beat;

  logic [NW-1:0]                       w_nnz_c;
  logic [NW:0]                         w_nb;
  logic                                w_send;
  logic                                w_last;
  logic                                w_fire;
  logic                                w_accept;
  logic [BEAT_WORDS*WORD_WIDTH-1:0]    w_lifm;
  logic [BEAT_WORDS*MTW-1:0]           w_mt;
  logic [BEAT_WORDS-1:0]               w_mask;

  assign w_nnz_c = (nnz > NW'(LINE_SIZE)) ? NW'(LINE_SIZE) : nnz;

  // Beats needed for the held line. An empty line gives w_nb = 0, and the
  // "beat+1 >= w_nb" test below then marks beat 0 as last, so it still
  // produces exactly one (empty) beat carrying the line boundary.
  assign w_nb   = ({1'b0, r_nnz} + (NW+1)'(BEAT_WORDS - 1)) / (NW+1)'(BEAT_WORDS);
  assign w_last = ((NW+1)'(r_beat) + (NW+1)'(1)) >= w_nb;

  assign w_send   = (r_state == S_SEND);
  assign w_fire   = w_send && out_ready;
  assign in_ready = !w_send || (w_fire && w_last);
  assign w_accept = in_valid && in_ready;

  // Select the current beat's words; anything at or beyond nnz is zeroed.
  always_comb begin
    w_lifm = '0;
    w_mt   = '0;
    w_mask = '0;
    for (int j = 0; j < BEAT_WORDS; j++) begin
      if (w_send && ((int'(r_beat) * BEAT_WORDS + j) < int'(r_nnz))) begin
        w_mask[j] = 1'b1;
        w_lifm[j*WORD_WIDTH +: WORD_WIDTH] =
          r_lifm[(int'(r_beat) * BEAT_WORDS + j) * WORD_WIDTH +: WORD_WIDTH];
        w_mt[j*MTW +: MTW] =
          r_mt[(int'(r_beat) * BEAT_WORDS + j) * MTW +: MTW];
      end
    end
  end

  // Outputs are decoded from state, so reset clears out_valid asynchronously.
  assign out_valid    = w_send;
  assign out_lifm     = w_lifm;
  assign out_mt       = w_mt;
  assign out_mask     = w_mask;
  assign out_beat_idx = w_send ? r_beat : '0;
  assign out_last     = w_send && w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_lifm  <= '0;
      r_mt    <= '0;
      r_nnz   <= '0;
      r_beat  <= '0;
    end else if (w_accept) begin
      // Covers both IDLE capture and the no-bubble refill on the final beat.
      r_state <= S_SEND;
      r_lifm  <= lifm_comp;
      r_mt    <= mt_comp;
      r_nnz   <= w_nnz_c;
      r_beat  <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_state <= S_IDLE;
      end else begin
        r_beat <= r_beat + BIW'(1);
      end
    end
  end

`ifdef ZVC_SER_PERF_EN
  logic [31:0] r_perf_lines;
  logic [31:0] r_perf_beats;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_lines <= '0;
      r_perf_beats <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept && (r_perf_lines != '1)) r_perf_lines <= r_perf_lines + 32'd1;
      if (w_fire && (r_perf_beats != '1))   r_perf_beats <= r_perf_beats + 32'd1;
      if (w_send && !out_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_lines = r_perf_lines;
  assign perf_beats = r_perf_beats;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_zvc_line_serializer.sv
// Purpose : self-checking bench for zvc_line_serializer.
// Latency : n/a (bench).
// Backpr. : drives out_ready both steady and randomly.
module tb_zvc_line_serializer;
  localparam int WW  = 8;
  localparam int LS  = 128;
  localparam int MTW = 28;
  localparam int BW  = 16;
  localparam int NW  = 8;
  localparam int BIW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [LS*WW-1:0]     lifm_comp;
  logic [LS*MTW-1:0]    mt_comp;
  logic [NW-1:0]        nnz;
  logic [BW*WW-1:0]     out_lifm;
  logic [BW*MTW-1:0]    out_mt;
  logic [BW-1:0]        out_mask;
  logic [BIW-1:0]       out_beat_idx;
`ifdef ZVC_SER_PERF_EN
  logic [31:0]          perf_lines, perf_beats, perf_stall;
`endif

  zvc_line_serializer #(
    .WORD_WIDTH(8), .LINE_SIZE(128), .DIST_WIDTH(7), .MAX_LIFM_RSIZ(4), .BEAT_WORDS(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .lifm_comp(lifm_comp), .mt_comp(mt_comp), .nnz(nnz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lifm(out_lifm), .out_mt(out_mt), .out_mask(out_mask),
    .out_beat_idx(out_beat_idx),
`ifdef ZVC_SER_PERF_EN
    .perf_lines(perf_lines), .perf_beats(perf_beats), .perf_stall(perf_stall),
`endif
    .out_last(out_last)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model: expected beats per accepted line ----------
  typedef struct {
    logic [BW*WW-1:0]  lifm;
    logic [BW*MTW-1:0] mt;
    logic [BW-1:0]     mask;
    int                idx;
    bit                last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    m_lines, m_beats, m_stall;
  bit    held;
  logic [BW*WW-1:0]  h_lifm;
  logic [BW*MTW-1:0] h_mt;
  logic [BW+BIW+1:0] h_ctl;

  task automatic push_line();
    int nc, nb;
    beat_t e;
    nc = (int'(nnz) > LS) ? LS : int'(nnz);
    nb = (nc == 0) ? 1 : (nc + BW - 1) / BW;
    for (int b = 0; b < nb; b++) begin
      e.lifm = '0; e.mt = '0; e.mask = '0;
      e.idx  = b;  e.last = (b == nb - 1);
      for (int j = 0; j < BW; j++) begin
        if (b * BW + j < nc) begin
          e.mask[j]          = 1'b1;
          e.lifm[j*WW +: WW]   = lifm_comp[(b*BW + j)*WW +: WW];
          e.mt[j*MTW +: MTW]   = mt_comp[(b*BW + j)*MTW +: MTW];
        end
      end
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      held = 0; m_lines = 0; m_beats = 0; m_stall = 0;
    end else begin
      if (held) begin
        chk("hold_lifm", out_lifm, h_lifm);
        chk("hold_mt", out_mt, h_mt);
        chk("hold_ctl", {out_valid, out_mask, out_beat_idx, out_last}, h_ctl);
      end
      held = 0;
      if (out_valid && out_ready) begin
        m_beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_lifm", out_lifm, mon_e.lifm);
          chk("beat_mt", out_mt, mon_e.mt);
          chk("beat_ctl", {out_mask, out_beat_idx, out_last},
              {mon_e.mask, BIW'(mon_e.idx), mon_e.last});
          chk("in_ready_on_hs", in_ready, mon_e.last);
        end
      end else if (out_valid) begin
        m_stall++;
        held   = 1;
        h_lifm = out_lifm;
        h_mt   = out_mt;
        h_ctl  = {1'b1, out_mask, out_beat_idx, out_last};
        chk("in_ready_stall", in_ready, 0);
      end
      if (in_valid && in_ready) begin
        m_lines++;
        push_line();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic randomize_line();
    for (int i = 0; i < LS; i++) begin
      lifm_comp[i*WW +: WW]   = WW'($urandom);
      mt_comp[i*MTW +: MTW]   = MTW'($urandom);
    end
  endtask

  // Offers one line, waits for its accept, then runs it to out_last with out_ready=1.
  task automatic drive_line(input int n, output int nbeats, output logic [15:0] lmask,
                            output int lat);
    int  k;
    bit  done;
    @(posedge clk); #1;
    randomize_line();
    nnz = NW'(n); in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    nbeats = 0; lmask = '0; lat = 0; done = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (nbeats == 0) lat = c;
        nbeats++;
        if (out_last) begin lmask = out_mask; done = 1; end
      end
    end
    if (!done) chk("line_timeout", 0, 1);
  endtask

  typedef struct { int nnz; int nb; logic [15:0] lmask; } vec_t;
  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, lat, gaps, base, k, sent;
    bit pend, done;
    logic [15:0] lm;

    vt[0] = '{0,   1, 16'h0000};
    vt[1] = '{40,  3, 16'h00FF};
    vt[2] = '{128, 8, 16'hFFFF};
    vt[3] = '{16,  1, 16'hFFFF};
    vt[4] = '{33,  3, 16'h0001};
    vt[5] = '{200, 8, 16'hFFFF};
    vt[6] = '{1,   1, 16'h0001};
    vt[7] = '{255, 8, 16'hFFFF};
    vt[8] = '{127, 8, 16'h7FFF};
    vt[9] = '{17,  2, 16'h0001};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; nnz = '0;
    lifm_comp = '0; mt_comp = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_lifm", out_lifm, 0);
    chk("rst_out_mt", out_mt, 0);
    chk("rst_out_ctl", {out_mask, out_beat_idx, out_last}, 0);
`ifdef ZVC_SER_PERF_EN
    chk("rst_perf", {perf_lines, perf_beats, perf_stall}, 0);
`endif
    #2 reset_n = 1'b1;

    // Table-driven single lines with continuous out_ready.
    for (int i = 0; i < 10; i++) begin
      drive_line(vt[i].nnz, nb, lm, lat);
      chk($sformatf("vec%0d_nbeats", i), nb, vt[i].nb);
      chk($sformatf("vec%0d_lastmask", i), lm, vt[i].lmask);
      chk($sformatf("vec%0d_latency", i), lat, 1);
    end

    // Back-to-back lines: 128 then 16, no idle cycle between.
    @(posedge clk); #1;
    randomize_line(); nnz = 8'd128; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    randomize_line(); nnz = 8'd16;
    gaps = 0;
    for (int b = 0; b < 9; b++) begin
      @(negedge clk);
      if (!out_valid) gaps++;
      if (b == 7) begin
        chk("b2b_in_ready_beat7", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
      end
      if (b == 8) chk("b2b_second_line", {out_last, out_beat_idx}, {1'b1, 3'd0});
    end
    chk("b2b_no_bubble", gaps, 0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_after", out_valid, 0);

    // nnz = 33 with out_ready low for 5 cycles on beat 1.
    @(posedge clk); #1;
    randomize_line(); nnz = 8'd33; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;
    base = m_stall;
    @(negedge clk);
    chk("stall_on_beat1", {out_valid, out_beat_idx}, {1'b1, 3'd1});
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) done = 1;
    end
    if (!done) chk("stall_timeout", 0, 1);
    @(posedge clk); #1;
    chk("stall_cycles", m_stall - base, 5);
`ifdef ZVC_SER_PERF_EN
    chk("perf_stall_after_stall", perf_stall, m_stall);
`endif

    // Reset on beat 3 of 8.
    @(posedge clk); #1;
    randomize_line(); nnz = 8'd128; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!(out_valid && out_beat_idx == 3'd3) && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) chk("rst_mid_timeout", 0, 1);
    #1 reset_n = 1'b0;
    #1 chk("rst_mid_valid_async", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_valid_after", out_valid, 0);
    drive_line(16, nb, lm, lat);
    chk("rst_mid_newline_nbeats", nb, 1);
    chk("rst_mid_newline_mask", lm, 16'hFFFF);

    // Random lines with random backpressure, checked by the model.
    pend = 0; sent = 0;
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      if (pend) begin in_valid = 1'b0; pend = 0; end
      if (!in_valid && sent < 40 && $urandom_range(0, 2) == 0) begin
        randomize_line();
        nnz = NW'($urandom_range(0, 255));
        in_valid = 1'b1;
        sent++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) pend = 1;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", out_valid, 0);
`ifdef ZVC_SER_PERF_EN
    chk("perf_lines", perf_lines, m_lines);
    chk("perf_beats", perf_beats, m_beats);
    chk("perf_stall", perf_stall, m_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zvc_line_serializer.md
Name: zvc_line_serializer

Overview:
- Sits directly downstream of the zero-value compressor pipeline.
- Accepts one compressed line per handshake: non-zero LIFM words packed at low indices, the matching mapping-table entries, and the non-zero count.
- Emits the line as fixed-width beats on a valid/ready stream toward the on-chip buffer write port.
- Sends only beats that hold valid words, so bandwidth scales with density.

Parameters:
- WORD_WIDTH, 8: bits per LIFM word.
- LINE_SIZE, 128: words per line; must be a multiple of BEAT_WORDS.
- DIST_WIDTH, 7: bits per mapping-table distance field.
- MAX_LIFM_RSIZ, 4: distance fields per word. The mapping-table entry width MTW is DIST_WIDTH*MAX_LIFM_RSIZ.
- BEAT_WORDS, 16: words per output beat. NBEATS is LINE_SIZE/BEAT_WORDS.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  compressed line present.
- in_ready  out  1  block accepts the line this cycle.
- lifm_comp  in  LINE_SIZE*WORD_WIDTH  packed words; word i is at bits [i*WORD_WIDTH +: WORD_WIDTH].
- mt_comp  in  LINE_SIZE*MTW  packed mapping-table entries, same indexing as lifm_comp.
- nnz  in  $clog2(LINE_SIZE)+1  number of valid words, range 0..LINE_SIZE.
- out_valid  out  1  beat present.
- out_ready  in  1  downstream takes the beat.
- out_lifm  out  BEAT_WORDS*WORD_WIDTH  beat words.
- out_mt  out  BEAT_WORDS*MTW  beat mapping-table entries.
- out_mask  out  BEAT_WORDS  per-word valid bits.
- out_beat_idx  out  $clog2(NBEATS)  beat index within the line.
- out_last  out  1  final beat of the line.

Behaviour:
- Reset values: every output is 0 except in_ready = 1. State is IDLE, the line register and nnz register are cleared, and the beat counter is 0.
- Reset mid-line: the line in flight is dropped with no partial completion. out_valid falls asynchronously with reset_n.
- FSM states are IDLE and SEND.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture lifm_comp, mt_comp and clamped nnz; set beat counter to 0; go to SEND.
  - No beat is emitted in the capture cycle; latency is 1 cycle.
- nnz clamping: values above LINE_SIZE are treated as LINE_SIZE.
- Beat count: nb = ceil(nnz_c/BEAT_WORDS), forced to 1 when nnz_c = 0. An empty line still produces one beat with out_mask = 0 and out_last = 1, so downstream sees the line boundary.
- SEND, per beat b:
  - out_valid = 1 and out_beat_idx = b.
  - Word j of the beat carries line word b*BEAT_WORDS+j.
  - out_mask[j] = 1 when (b*BEAT_WORDS+j) < nnz_c.
  - Words and mt entries with mask 0 are driven as 0.
  - out_last = 1 when b = nb-1.
- Beat advance: when out_valid and out_ready, increment b.
- Final beat:
  - in_ready = 1 in the cycle the final beat handshakes.
  - If in_valid is also high, capture the next line and stay in SEND with b = 0. There is no bubble between lines.
  - Otherwise return to IDLE.
- In SEND, in_ready = 0 in all other cycles.
- Backpressure: while out_valid and not out_ready, all out_* signals hold stable and the line register does not change.
- Arithmetic: the nnz comparisons use unsigned width $clog2(LINE_SIZE)+1. The beat counter never wraps within a line.

Optional Feature:
- Macro: ZVC_SER_PERF_EN.
- When defined, three extra outputs are present, all 32 bits, reset to 0 and saturating at all-ones:
  - perf_lines: increments on each in_valid & in_ready.
  - perf_beats: increments on each out_valid & out_ready.
  - perf_stall: increments on each cycle with out_valid & !out_ready.
- When not defined, these ports and their counters do not exist and the rest of the behaviour is unchanged.

Test Plan:
- nnz = 40, out_ready held 1 → 3 beats on consecutive cycles starting 1 cycle after accept. out_mask = FFFF, FFFF, 00FF. out_beat_idx = 0, 1, 2. out_last only on beat 2. Words 40..47 are zero.
- nnz = 0 → exactly one beat with out_mask = 0, out_lifm = 0, out_last = 1. in_ready is high in the same cycle as that beat's handshake.
- Two lines back to back (nnz = 128 then nnz = 16), out_ready = 1 → 8 beats then 1 beat with no idle cycle between them. in_ready pulses on the handshake of beat 7.
- nnz = 33 with out_ready low for 5 cycles on beat 1 → out_* on beat 1 stays unchanged for 5 cycles, then the transfer completes. perf_stall = 5 when ZVC_SER_PERF_EN is defined.
- nnz = 200 → treated as 128: 8 full beats, all masks FFFF.
- reset_n asserted on beat 3 of 8 → out_valid = 0 immediately and in_ready = 1 after release. A new line with nnz = 16 then produces 1 beat with correct data.
